// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Optional statistics counters are enabled with DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int STAT_W = 16;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                input logic              en);
    return (en && (v != {STAT_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating event counters for the arbiter: port 0 grants, port 1 grants
// and contended cycles. Only instantiated when DMEM_ARB_STATS_EN is defined.
module dmem_arb_stats
  import dmem_arb_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              gnt0_i,
  input  logic              gnt1_i,
  input  logic              conflict_i,
  output logic [STAT_W-1:0] stat_gnt0_o,
  output logic [STAT_W-1:0] stat_gnt1_o,
  output logic [STAT_W-1:0] stat_conflict_o
);

  logic [2:0] inc;

  assign inc = {conflict_i, gnt1_i, gnt0_i};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [STAT_W-1:0] cnt_q;

    always_ff @(posedge Clock) begin
      if (Reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= sat_inc(cnt_q, inc[gi]);
      end
    end
  end

  assign stat_gnt0_o     = g_cnt[0].cnt_q;
  assign stat_gnt1_o     = g_cnt[1].cnt_q;
  assign stat_conflict_o = g_cnt[2].cnt_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-master round-robin arbiter for the single dmem port, with bounded burst
// lock. Define DMEM_ARB_STATS_EN to add the stat_* counter outputs.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 4
) (
  input  logic              Clock,
  input  logic              Reset,

  input  logic              p0_req,
  input  logic              p0_wr,
  input  logic              p0_lock,
  input  logic [0:ADDR_W-1] p0_addr,
  input  logic [0:DATA_W-1] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [0:DATA_W-1] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_wr,
  input  logic              p1_lock,
  input  logic [0:ADDR_W-1] p1_addr,
  input  logic [0:DATA_W-1] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [0:DATA_W-1] p1_rdata,

  output logic              DmemEn,
  output logic              DmemWrEn,
  output logic [0:ADDR_W-1] Mem_Addr,
  output logic [0:DATA_W-1] Data_Out,
  input  logic [0:DATA_W-1] Data_In
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_gnt0,
  output logic [STAT_W-1:0] stat_gnt1,
  output logic [STAT_W-1:0] stat_conflict
`endif
);

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [3:0] burst_q, burst_d;
  logic [1:0] rvalid_q;

  logic [1:0]        req, wr, lock, gnt;
  logic [0:ADDR_W-1] addr_v  [2];
  logic [0:DATA_W-1] wdata_v [2];
  logic              sel;
  logic              hold;
  logic [3:0]        burst_inc;

  assign req        = {p1_req, p0_req};
  assign wr         = {p1_wr, p0_wr};
  assign lock       = {p1_lock, p0_lock};
  assign addr_v[0]  = p0_addr;
  assign addr_v[1]  = p1_addr;
  assign wdata_v[0] = p0_wdata;
  assign wdata_v[1] = p1_wdata;

  // Grant selection and next-state. A locked owner that stops requesting
  // releases the lock in the same cycle, so ordinary arbitration applies.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    burst_d   = burst_q;
    gnt       = 2'b00;
    sel       = P0;
    hold      = (state_q == LOCKED) && req[owner_q];
    burst_inc = burst_q + 4'd1;

    if (Reset) begin
      gnt = 2'b00;
    end else if (hold) begin
      sel      = owner_q;
      gnt[sel] = 1'b1;
      burst_d  = burst_inc;
      if (!lock[sel] || (burst_inc >= MAX_BURST_C)) begin
        state_d = ARB;
        burst_d = 4'd0;
      end
    end else begin
      state_d = ARB;
      burst_d = 4'd0;
      if (req[0] && req[1]) begin
        sel = ~last_q;
      end else begin
        sel = req[1] ? P1 : P0;
      end
      if (req[0] || req[1]) begin
        gnt[sel] = 1'b1;
        if (lock[sel] && (MAX_BURST > 1)) begin
          state_d = LOCKED;
          owner_d = sel;
          burst_d = 4'd1;
        end
      end
    end

    if (gnt != 2'b00) begin
      last_d = sel;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ARB;
      owner_q  <= P0;
      last_q   <= P1;
      burst_q  <= 4'd0;
      rvalid_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      rvalid_q <= gnt & ~wr;
    end
  end

  assign p0_gnt = gnt[0];
  assign p1_gnt = gnt[1];

  assign DmemEn   = gnt[0] | gnt[1];
  assign DmemWrEn = DmemEn & wr[sel];
  assign Mem_Addr = DmemEn ? addr_v[sel]  : '0;
  assign Data_Out = DmemEn ? wdata_v[sel] : '0;

  // Masking with Reset suppresses a return whose grant preceded a reset.
  assign p0_rvalid = rvalid_q[0] & ~Reset;
  assign p1_rvalid = rvalid_q[1] & ~Reset;
  assign p0_rdata  = Data_In;
  assign p1_rdata  = Data_In;

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats u_stats (
    .Clock           (Clock),
    .Reset           (Reset),
    .gnt0_i          (gnt[0]),
    .gnt1_i          (gnt[1]),
    .conflict_i      (req[0] & req[1] & ~Reset),
    .stat_gnt0_o     (stat_gnt0),
    .stat_gnt1_o     (stat_gnt1),
    .stat_conflict_o (stat_conflict)
  );
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed scenarios then random
// traffic, checked against a behavioural arbitration and memory model.
module tb_dmem_port_arbiter;
  import dmem_arb_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 64;
  localparam int MAX_BURST = 4;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              p0_req = 1'b0, p0_wr = 1'b0, p0_lock = 1'b0;
  logic [0:ADDR_W-1] p0_addr = '0;
  logic [0:DATA_W-1] p0_wdata = '0;
  logic              p1_req = 1'b0, p1_wr = 1'b0, p1_lock = 1'b0;
  logic [0:ADDR_W-1] p1_addr = '0;
  logic [0:DATA_W-1] p1_wdata = '0;
  logic              p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [0:DATA_W-1] p0_rdata, p1_rdata;
  logic              DmemEn, DmemWrEn;
  logic [0:ADDR_W-1] Mem_Addr;
  logic [0:DATA_W-1] Data_Out;
  logic [0:DATA_W-1] Data_In = '0;
`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

  always #5 Clock = ~Clock;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .Clock(Clock), .Reset(Reset),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_lock(p0_lock), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_lock(p1_lock), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .DmemEn(DmemEn), .DmemWrEn(DmemWrEn), .Mem_Addr(Mem_Addr),
    .Data_Out(Data_Out), .Data_In(Data_In)
`ifdef DMEM_ARB_STATS_EN
    , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
`endif
  );

  function automatic logic [0:DATA_W-1] init_word(input int i);
    return {32'(i) * 32'h9E3779B9, 32'(i) ^ 32'hA5A50000};
  endfunction

  // dmem stand-in: one-cycle read latency, garbage on Data_In when not reading.
  logic [0:DATA_W-1] mem [256];
  bit                mem_written [256];
  always @(posedge Clock) begin
    if (DmemEn && DmemWrEn) begin
      mem[Mem_Addr]         <= Data_Out;
      mem_written[Mem_Addr] <= 1'b1;
    end
    if (DmemEn && !DmemWrEn)
      Data_In <= mem_written[Mem_Addr] ? mem[Mem_Addr] : init_word(int'(Mem_Addr));
    else
      Data_In <= {$urandom, $urandom};
  end

  // Scoreboard
  typedef struct {
    int                cyc;
    int                port;
    logic              wr;
    logic [0:ADDR_W-1] addr;
    logic [0:DATA_W-1] wdata;
  } gexp_t;
  typedef struct {
    int                due;
    int                port;
    logic [0:DATA_W-1] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  // Reference model state
  logic [0:DATA_W-1] ref_mem [256];
  bit                ref_written [256];
  int m_owner = -1, m_used = 0, m_last = 1, m_gnt = -1;
  int cnt_g0 = 0, cnt_g1 = 0, cnt_conf = 0;
  int s_g0 = 0, s_g1 = 0, s_conf = 0;

  // Requester intent
  bit                r_reset = 1'b1;
  bit                r_req  [2];
  bit                r_wr   [2];
  bit                r_lock [2];
  logic [0:ADDR_W-1] r_addr [2];
  logic [0:DATA_W-1] r_wdata[2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic set_req(input int n, input bit wr, input bit lk,
                         input logic [0:ADDR_W-1] a, input logic [0:DATA_W-1] d);
    r_req[n] = 1'b1; r_wr[n] = wr; r_lock[n] = lk; r_addr[n] = a; r_wdata[n] = d;
  endtask

  task automatic predict();
    s_g0 = cnt_g0; s_g1 = cnt_g1; s_conf = cnt_conf;
    m_gnt = -1;
    if (r_reset) begin
      m_owner = -1; m_used = 0; m_last = 1;
      cnt_g0 = 0; cnt_g1 = 0; cnt_conf = 0;
      while (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
    end else begin
      if (r_req[0] && r_req[1] && cnt_conf < 65535) cnt_conf++;
      if (m_owner >= 0 && r_req[m_owner]) begin
        m_gnt = m_owner;
        m_used++;
        if (!r_lock[m_gnt] || m_used >= MAX_BURST) m_owner = -1;
      end else begin
        m_owner = -1;
        if (r_req[0] && r_req[1]) m_gnt = 1 - m_last;
        else if (r_req[0])        m_gnt = 0;
        else if (r_req[1])        m_gnt = 1;
        if (m_gnt >= 0 && r_lock[m_gnt] && MAX_BURST > 1) begin
          m_owner = m_gnt;
          m_used  = 1;
        end
      end
      if (m_gnt >= 0) begin
        m_last = m_gnt;
        if (m_gnt == 0 && cnt_g0 < 65535) cnt_g0++;
        if (m_gnt == 1 && cnt_g1 < 65535) cnt_g1++;
        gq.push_back('{cyc, m_gnt, r_wr[m_gnt], r_addr[m_gnt], r_wdata[m_gnt]});
        if (r_wr[m_gnt]) begin
          ref_mem[r_addr[m_gnt]]     = r_wdata[m_gnt];
          ref_written[r_addr[m_gnt]] = 1'b1;
        end else begin
          rq.push_back('{cyc + 1, m_gnt,
                         ref_written[r_addr[m_gnt]] ? ref_mem[r_addr[m_gnt]]
                                                    : init_word(int'(r_addr[m_gnt]))});
        end
        r_req[m_gnt] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    cyc++;
    Reset = r_reset;
    p0_req = r_req[0]; p0_wr = r_wr[0]; p0_lock = r_lock[0]; p0_addr = r_addr[0]; p0_wdata = r_wdata[0];
    p1_req = r_req[1]; p1_wr = r_wr[1]; p1_lock = r_lock[1]; p1_addr = r_addr[1]; p1_wdata = r_wdata[1];
    predict();
  endtask

  task automatic do_reset();
    r_reset = 1'b1;
    step();
    step();
    r_reset = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((r_req[0] || r_req[1]) && k < 20) begin
      step();
      k++;
    end
    if (k == 20) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout cyc=%0d actual=pending required=idle", cyc);
    end
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic check_stats();
    @(negedge Clock);
    chk("stat_gnt0", 128'(stat_gnt0), 128'(s_g0));
    chk("stat_gnt1", 128'(stat_gnt1), 128'(s_g1));
    chk("stat_conflict", 128'(stat_conflict), 128'(s_conf));
  endtask
`endif

  // Monitor: compares whatever the DUT presents against the queues.
  initial begin
    gexp_t e;
    rexp_t r;
    forever begin
      @(negedge Clock);
      if (p0_gnt || p1_gnt || (gq.size() > 0 && gq[0].cyc == cyc)) begin
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
          e = gq.pop_front();
          chk("grant", {p0_gnt, p1_gnt, DmemEn, DmemWrEn, Mem_Addr, Data_Out},
              {1'(e.port == 0), 1'(e.port == 1), 1'b1, e.wr, e.addr, e.wdata});
        end else begin
          chk("unexpected_grant", {p0_gnt, p1_gnt}, 2'b00);
        end
      end else begin
        chk("idle_mem", {DmemEn, DmemWrEn, Mem_Addr, Data_Out}, '0);
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        chk("rvalid", {p0_rvalid, p1_rvalid, (r.port == 0) ? p0_rdata : p1_rdata},
            {1'(r.port == 0), 1'(r.port == 1), r.data});
      end else begin
        chk("no_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
      end
    end
  end

  initial begin
    int p1_cnt;
    int k;
    for (int i = 0; i < 256; i++) ref_written[i] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      r_req[n] = 0; r_wr[n] = 0; r_lock[n] = 0; r_addr[n] = '0; r_wdata[n] = '0;
    end
    repeat (3) step();
    r_reset = 1'b0;

    // Single read from port 0
    set_req(0, 1'b0, 1'b0, 8'h10, 64'h0123456789ABCDEF);
    step();
    step();
    step();

    // Sustained contention alternates
    do_reset();
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < 2; n++)
        if (!r_req[n]) set_req(n, 1'b0, 1'b0, 8'(8'h30 + i * 2 + n), {$urandom, $urandom});
      step();
    end
    step();
`ifdef DMEM_ARB_STATS_EN
    check_stats();
`endif

    // Write by port 1 then read-back by port 0
    set_req(1, 1'b1, 1'b0, 8'h20, 64'hDEADBEEF_00000001);
    step();
    set_req(0, 1'b0, 1'b0, 8'h20, 64'h0);
    step();
    step();

    // Port 1 burst lock against continuous port 0 traffic
    p1_cnt = 0;
    k = 0;
    while (p1_cnt < 6 && k < 20) begin
      if (!r_req[0]) set_req(0, 1'b0, 1'b0, 8'($urandom_range(31)), {$urandom, $urandom});
      if (!r_req[1]) set_req(1, 1'b0, 1'b1, 8'($urandom_range(31)), {$urandom, $urandom});
      step();
      if (m_gnt == 1) p1_cnt++;
      k++;
    end
    if (k == 20) begin
      n_checks++; n_fail++;
      $display("FAIL burst_timeout cyc=%0d actual=%0d required=6", cyc, p1_cnt);
    end
    r_req[1] = 1'b0;
    drain();

    // Locked owner drops request, other port wins the same cycle
    do_reset();
    set_req(0, 1'b0, 1'b1, 8'h05, 64'h0);
    set_req(1, 1'b0, 1'b0, 8'h06, 64'h0);
    step();
    set_req(0, 1'b0, 1'b1, 8'h07, 64'h0);
    step();
    step();
    drain();

    // Reset in the cycle after a locked read grant
    do_reset();
    set_req(0, 1'b0, 1'b1, 8'h10, 64'h0);
    set_req(1, 1'b1, 1'b0, 8'h11, 64'h55);
    step();
    set_req(0, 1'b0, 1'b1, 8'h12, 64'h0);
    step();
    r_reset = 1'b1;
    step();
    step();
    r_reset = 1'b0;
    set_req(0, 1'b0, 1'b0, 8'h13, 64'h0);
    step();
    drain();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r_reset = ($urandom_range(199) == 0);
      for (int n = 0; n < 2; n++) begin
        if (!r_req[n]) begin
          if ($urandom_range(99) < 60)
            set_req(n, 1'($urandom_range(1)), ($urandom_range(99) < 35),
                    8'($urandom_range(31)), {$urandom, $urandom});
          else begin
            r_wr[n] = 1'($urandom_range(1)); r_lock[n] = 1'($urandom_range(1));
            r_addr[n] = 8'($urandom); r_wdata[n] = {$urandom, $urandom};
          end
        end
      end
      step();
    end
    r_reset = 1'b0;
    drain();
    step();
    step();
`ifdef DMEM_ARB_STATS_EN
    check_stats();
`endif
    @(negedge Clock);
    chk("queues_drained", 128'(gq.size() + rq.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
